// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction handshake and datapath control strobes for instr_sequencer
interface instr_sequencer_if;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic        err;
    logic [2:0]  rnum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    modport master (
        output s, in,
        input  w, err, rnum, write, vsel, loada, loadb, loadc, loads, asel, bsel, aluop, shift
    );
    modport slave (
        input  s, in,
        output w, err, rnum, write, vsel, loada, loadb, loadc, loads, asel, bsel, aluop, shift
    );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle Moore control FSM for the Simple RISC Machine datapath
module instr_sequencer (
    input  logic             clk,
    input  logic             reset,
    instr_sequencer_if.slave bus
);
    typedef enum logic [2:0] {WAIT, DECODE, WIMM, GETA, GETB, EXEC, WRB} state_t;
    state_t      r_state, w_next;
    logic [15:0] r_ir;
    logic        w_movi, w_movr, w_alu, w_cmp, w_mvn;
    assign w_movi = r_ir[15:13] == 3'b110 && r_ir[12:11] == 2'b10;
    assign w_movr = r_ir[15:13] == 3'b110 && r_ir[12:11] == 2'b00;
    assign w_alu  = r_ir[15:13] == 3'b101;
    assign w_cmp  = w_alu && r_ir[12:11] == 2'b01;
    assign w_mvn  = w_alu && r_ir[12:11] == 2'b11;
    assign bus.bsel = 1'b0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == WAIT && bus.s) r_ir <= bus.in;
        end
    end
    always_comb begin
        w_next    = WAIT;
        bus.w     = 1'b0;
        bus.err   = 1'b0;
        bus.rnum  = 3'd0;
        bus.write = 1'b0;
        bus.vsel  = 1'b0;
        bus.loada = 1'b0;
        bus.loadb = 1'b0;
        bus.loadc = 1'b0;
        bus.loads = 1'b0;
        bus.asel  = 1'b0;
        bus.aluop = 2'b00;
        bus.shift = 2'b00;
        case (r_state)
            WAIT: begin
                bus.w  = 1'b1;
                w_next = bus.s ? DECODE : WAIT;
            end
            DECODE: begin
                w_next  = w_movi ? WIMM : (w_movr || w_mvn) ? GETB : w_alu ? GETA : WAIT;
                bus.err = !(w_movi || w_movr || w_alu);
            end
            WIMM: begin
                bus.rnum  = r_ir[10:8];
                bus.vsel  = 1'b1;
                bus.write = 1'b1;
            end
            GETA: begin
                bus.rnum  = r_ir[10:8];
                bus.loada = 1'b1;
                w_next    = GETB;
            end
            GETB: begin
                bus.rnum  = r_ir[2:0];
                bus.loadb = 1'b1;
                w_next    = EXEC;
            end
            EXEC: begin
                bus.asel  = w_movr || w_mvn;
                bus.aluop = w_alu ? r_ir[12:11] : 2'b00;
                bus.shift = r_ir[4:3];
                bus.loads = w_cmp;
                bus.loadc = !w_cmp;
                w_next    = w_cmp ? WAIT : WRB;
            end
            WRB: begin
                bus.rnum  = r_ir[7:5];
                bus.write = 1'b1;
            end
            default: w_next = WAIT;
        endcase
    end
endmodule
